apb_cmd_master: RTL and testbench
=================================

# apb_cmd_master

Command-execution stage of the UART-to-APB bridge, directly downstream of the UART receive path. It accepts one 56-bit command frame from the receiver's output register and decodes it into a read or write command. It runs that command as a single APB3 transfer, with a timeout on the completion, and returns a 40-bit status+data response to the UART transmit side. While a command is in flight it holds `full` high to back-pressure the receiver.

## Interface
- `TIMEOUT`, default 255: maximum consecutive ACCESS cycles with PREADY low before the transfer is aborted. Legal range is 1–65535.
- `clk` in 1: bridge clock, the same clock as the UART receive path.
- `rst` in 1: synchronous, active-high reset.
- `pdata` in 56: command frame from the receiver, split as follows.
  - [55:48] command byte.
  - [47:32] address.
  - [31:0] write data.
- `data_vld` in 1: frame valid. Captured only when `full`=0.
- `full` out 1: busy or back-pressure flag to the receiver.
- `PSEL`, `PENABLE`, `PWRITE` out 1 each: APB3 control.
- `PADDR` out 16: APB address.
- `PWDATA` out 32: APB write data.
- `PRDATA` in 32, `PREADY` in 1, `PSLVERR` in 1: APB3 completer response.
- `rsp_data` out 40: response to the transmit side.
  - [39:32] status.
  - [31:0] read data.
- `rsp_vld` out 1: response valid.
- `rsp_rdy` in 1: transmit side accepts the response.

## Operation
- Command decode:
  - 8'h57 ('W') is a write.
  - 8'h52 ('R') is a read.
  - Any other value is illegal.
- Status codes:
  - 8'h00 OK.
  - 8'h01 PSLVERR.
  - 8'h02 timeout.
  - 8'h03 illegal command.
- FSM states are IDLE, SETUP, ACCESS and RESP. Every output is registered or decoded from the state register only.
- IDLE:
  - `full`=0.
  - When `data_vld`=1, capture `pdata` into the cmd/addr/wdata registers.
  - Go to SETUP for a legal command.
  - Go to RESP with status 03 and rdata 0 for an illegal command. No APB activity occurs in that case.
- SETUP:
  - PSEL=1, PENABLE=0.
  - PADDR, PWRITE and PWDATA are driven from the captured frame. PWDATA is 0 for reads.
  - Always go to ACCESS.
- ACCESS:
  - PSEL=1, PENABLE=1, with address, control and data held stable.
  - If PREADY=1: latch the status (01 if PSLVERR else 00). Latch rdata as PRDATA for a read with no error, otherwise 0. Go to RESP.
  - Else, if the wait counter equals TIMEOUT−1: status 02, rdata 0, go to RESP.
  - Else increment the wait counter.
- RESP:
  - PSEL=0, PENABLE=0, `rsp_vld`=1. `rsp_data` is stable until accepted.
  - When `rsp_rdy`=1, go to IDLE.
- `full`=1 in SETUP, ACCESS and RESP.
- `data_vld` asserted while `full`=1 is ignored. Upstream holds the frame.
- Wait counter:
  - Width is ceil(log2(TIMEOUT+1)).
  - Cleared on entry to ACCESS.
  - Never wraps.
- PADDR and PWDATA hold their last values outside SETUP and ACCESS. PWRITE is 0 outside SETUP and ACCESS.

## Timing
- Reset values:
  - State IDLE.
  - `full`=0.
  - PSEL, PENABLE and PWRITE = 0.
  - PADDR=0, PWDATA=0.
  - `rsp_vld`=0, `rsp_data`=0.
  - Wait counter 0.
- Reset asserted in any state returns all outputs to their reset values at the next edge, including an aborted APB transfer (PSEL drops immediately).
- Latency for a legal command, with `data_vld` sampled at edge N:
  - SETUP visible after N, so PSEL=1 and `full`=1 in cycle N+1.
  - PENABLE=1 in cycle N+2.
  - With PREADY=1 in cycle N+2, RESP is visible in cycle N+3: `rsp_vld`=1, PSEL=0.
- Wait states:
  - Each PREADY-low cycle in ACCESS adds one cycle of latency.
  - A timeout gives exactly TIMEOUT ACCESS cycles, then RESP.
- Illegal command: `rsp_vld`=1 in cycle N+1. PSEL never asserts.
- PREADY=1 in the same cycle the counter reaches TIMEOUT−1: the normal completion wins (status 00 or 01).
- `rsp_rdy` already high on RESP entry: RESP lasts one cycle and IDLE is visible in the next cycle. The earliest next capture is that IDLE cycle, i.e. back-to-back minimum period = 4 cycles.
- `rsp_rdy` low: stay in RESP indefinitely with `full`=1.
- PSLVERR and PRDATA are sampled only in ACCESS with PREADY=1.

## Test plan
- Write:
  - Stimulus: pdata=57_1234_DEADBEEF with data_vld, PREADY=1 immediately, rsp_rdy=1.
  - Required: PADDR=1234, PWDATA=DEADBEEF, PWRITE=1; SETUP in N+1, ACCESS in N+2; rsp_data=00_00000000 in N+3.
- Read with wait states:
  - Stimulus: 52_00A0_xxxxxxxx; PREADY low for 3 cycles then high with PRDATA=CAFEF00D.
  - Required: PWRITE=0, PENABLE high for 4 cycles, rsp_data=00_CAFEF00D.
- Slave error:
  - Stimulus: a read completing with PSLVERR=1 and PRDATA=FFFFFFFF.
  - Required: rsp_data=01_00000000.
- Timeout:
  - Stimulus: TIMEOUT=4 and PREADY held low.
  - Required: exactly 4 ACCESS cycles, then PSEL drops and rsp_data=02_00000000.
- Illegal command plus back-pressure:
  - Stimulus: command 0x41; then a second frame presented while rsp_rdy=0 for 5 cycles.
  - Required: no PSEL; rsp_data=03_00000000 in N+1. `full` stays high and the second frame is not captured until rsp_rdy=1 returns the FSM to IDLE.
- Reset mid-ACCESS:
  - Stimulus: assert rst during a PREADY-low wait.
  - Required: PSEL, PENABLE and full are 0 after the next edge. A new write after reset completes normally.

Source files
------------

// File: rtl/apb_cmd_master_if.sv
// apb_cmd_master_if: command frame, APB3 and response signals of the command master
interface apb_cmd_master_if;
  logic [55:0] pdata;
  logic        data_vld;
  logic        full;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [15:0] PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;
  logic [39:0] rsp_data;
  logic        rsp_vld;
  logic        rsp_rdy;
  modport master (
    input  pdata, data_vld, PRDATA, PREADY, PSLVERR, rsp_rdy,
    output full, PSEL, PENABLE, PWRITE, PADDR, PWDATA, rsp_data, rsp_vld
  );
  modport slave (
    output pdata, data_vld, PRDATA, PREADY, PSLVERR, rsp_rdy,
    input  full, PSEL, PENABLE, PWRITE, PADDR, PWDATA, rsp_data, rsp_vld
  );
endinterface

// File: rtl/apb_cmd_master.sv
// apb_cmd_master: runs one decoded UART command as an APB3 transfer with timeout and returns status+data
module apb_cmd_master #(
  parameter int TIMEOUT = 255
) (
  input logic clk,
  input logic rst,
  apb_cmd_master_if.master bus
);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;
  state_t        state;
  logic          wr;
  logic [15:0]   paddr;
  logic [31:0]   pwdata;
  logic [CW-1:0] wcnt;
  logic [39:0]   rsp;
  logic [7:0]    cmd;
  logic          legal;
  assign cmd   = bus.pdata[55:48];
  assign legal = (cmd == 8'h57) || (cmd == 8'h52);
  assign bus.full     = state != IDLE;
  assign bus.PSEL     = (state == SETUP) || (state == ACCESS);
  assign bus.PENABLE  = state == ACCESS;
  assign bus.PWRITE   = bus.PSEL && wr;
  assign bus.PADDR    = paddr;
  assign bus.PWDATA   = pwdata;
  assign bus.rsp_vld  = state == RESP;
  assign bus.rsp_data = rsp;
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      wr     <= 1'b0;
      paddr  <= '0;
      pwdata <= '0;
      wcnt   <= '0;
      rsp    <= '0;
    end else begin
      case (state)
        IDLE: if (bus.data_vld) begin
          if (legal) begin
            wr     <= cmd == 8'h57;
            paddr  <= bus.pdata[47:32];
            pwdata <= (cmd == 8'h57) ? bus.pdata[31:0] : 32'h0;
            state  <= SETUP;
          end else begin
            rsp   <= {8'h03, 32'h0};
            state <= RESP;
          end
        end
        SETUP: begin
          wcnt  <= '0;
          state <= ACCESS;
        end
        ACCESS: begin
          // a completing PREADY takes priority over the timeout on the final wait cycle
          if (bus.PREADY) begin
            rsp   <= {bus.PSLVERR ? 8'h01 : 8'h00, (!wr && !bus.PSLVERR) ? bus.PRDATA : 32'h0};
            state <= RESP;
          end else if (wcnt == CW'(TIMEOUT - 1)) begin
            rsp   <= {8'h02, 32'h0};
            state <= RESP;
          end else begin
            wcnt <= wcnt + 1'b1;
          end
        end
        RESP: if (bus.rsp_rdy) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_apb_cmd_master.sv
// tb_apb_cmd_master: directed checks of apb_cmd_master with TIMEOUT=4
module tb_apb_cmd_master;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  int en;
  apb_cmd_master_if bus ();
  apb_cmd_master #(.TIMEOUT(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [55:0] frame);
    bus.pdata = frame;
    bus.data_vld = 1'b1;
    tick();
    bus.data_vld = 1'b0;
  endtask
  initial begin
    bus.pdata = '0;
    bus.data_vld = 1'b0;
    bus.PRDATA = '0;
    bus.PREADY = 1'b0;
    bus.PSLVERR = 1'b0;
    bus.rsp_rdy = 1'b1;
    tick();
    tick();
    chk("rst_full", bus.full, 0);
    chk("rst_psel", bus.PSEL, 0);
    chk("rst_penable", bus.PENABLE, 0);
    chk("rst_pwrite", bus.PWRITE, 0);
    chk("rst_paddr", bus.PADDR, 0);
    chk("rst_pwdata", bus.PWDATA, 0);
    chk("rst_rsp_vld", bus.rsp_vld, 0);
    chk("rst_rsp_data", bus.rsp_data, 0);
    rst = 1'b0;
    tick();
    // write, zero wait states
    bus.PREADY = 1'b1;
    send(56'h57_1234_DEADBEEF);
    chk("wr_setup_psel", bus.PSEL, 1);
    chk("wr_setup_penable", bus.PENABLE, 0);
    chk("wr_setup_full", bus.full, 1);
    chk("wr_paddr", bus.PADDR, 16'h1234);
    chk("wr_pwdata", bus.PWDATA, 32'hDEADBEEF);
    chk("wr_pwrite", bus.PWRITE, 1);
    tick();
    chk("wr_access_penable", bus.PENABLE, 1);
    chk("wr_access_psel", bus.PSEL, 1);
    tick();
    chk("wr_resp_vld", bus.rsp_vld, 1);
    chk("wr_resp_psel", bus.PSEL, 0);
    chk("wr_rsp_data", bus.rsp_data, 40'h00_00000000);
    tick();
    chk("wr_idle_full", bus.full, 0);
    chk("wr_idle_pwrite", bus.PWRITE, 0);
    chk("wr_hold_paddr", bus.PADDR, 16'h1234);
    chk("wr_hold_pwdata", bus.PWDATA, 32'hDEADBEEF);
    // read, 3 wait states; completion lands on the last pre-timeout cycle
    bus.PREADY = 1'b0;
    bus.PRDATA = 32'hCAFEF00D;
    send(56'h52_00A0_12345678);
    chk("rd_pwrite", bus.PWRITE, 0);
    chk("rd_pwdata", bus.PWDATA, 0);
    chk("rd_paddr", bus.PADDR, 16'h00A0);
    en = 0;
    for (int i = 0; i < 12 && !bus.rsp_vld; i++) begin
      if (bus.PENABLE) begin
        bus.PREADY = (en == 3);
        en++;
      end
      tick();
    end
    chk("rd_penable_cycles", en, 4);
    chk("rd_rsp_vld", bus.rsp_vld, 1);
    chk("rd_rsp_data", bus.rsp_data, 40'h00_CAFEF00D);
    tick();
    // slave error on a read
    bus.PREADY = 1'b1;
    bus.PSLVERR = 1'b1;
    bus.PRDATA = 32'hFFFFFFFF;
    send(56'h52_0010_00000000);
    tick();
    tick();
    chk("err_rsp_vld", bus.rsp_vld, 1);
    chk("err_rsp_data", bus.rsp_data, 40'h01_00000000);
    tick();
    bus.PSLVERR = 1'b0;
    // timeout with PREADY held low
    bus.PREADY = 1'b0;
    send(56'h57_0020_11111111);
    en = 0;
    for (int i = 0; i < 20 && !bus.rsp_vld; i++) begin
      if (bus.PENABLE) en++;
      tick();
    end
    chk("to_access_cycles", en, 4);
    chk("to_rsp_vld", bus.rsp_vld, 1);
    chk("to_psel", bus.PSEL, 0);
    chk("to_rsp_data", bus.rsp_data, 40'h02_00000000);
    tick();
    // illegal command, then back-pressure on a second frame
    bus.rsp_rdy = 1'b0;
    send(56'h41_0000_00000000);
    chk("ill_rsp_vld", bus.rsp_vld, 1);
    chk("ill_psel", bus.PSEL, 0);
    chk("ill_rsp_data", bus.rsp_data, 40'h03_00000000);
    bus.pdata = 56'h57_0030_AAAA5555;
    bus.data_vld = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_full", bus.full, 1);
      chk("bp_psel", bus.PSEL, 0);
      chk("bp_rsp_data", bus.rsp_data, 40'h03_00000000);
    end
    bus.rsp_rdy = 1'b1;
    tick();
    chk("bp_idle_full", bus.full, 0);
    chk("bp_idle_psel", bus.PSEL, 0);
    bus.PREADY = 1'b1;
    tick();
    bus.data_vld = 1'b0;
    chk("bp_setup_psel", bus.PSEL, 1);
    chk("bp_setup_paddr", bus.PADDR, 16'h0030);
    chk("bp_setup_pwdata", bus.PWDATA, 32'hAAAA5555);
    tick();
    tick();
    chk("bp_rsp_data", bus.rsp_data, 40'h00_00000000);
    tick();
    // reset during an ACCESS wait
    bus.PREADY = 1'b0;
    send(56'h57_0040_01020304);
    tick();
    tick();
    chk("mid_access_penable", bus.PENABLE, 1);
    rst = 1'b1;
    tick();
    chk("rst_mid_psel", bus.PSEL, 0);
    chk("rst_mid_penable", bus.PENABLE, 0);
    chk("rst_mid_full", bus.full, 0);
    chk("rst_mid_paddr", bus.PADDR, 0);
    rst = 1'b0;
    bus.PREADY = 1'b1;
    send(56'h57_0050_12121212);
    chk("post_paddr", bus.PADDR, 16'h0050);
    chk("post_pwrite", bus.PWRITE, 1);
    tick();
    tick();
    chk("post_rsp_vld", bus.rsp_vld, 1);
    chk("post_rsp_data", bus.rsp_data, 40'h00_00000000);
    tick();
    chk("post_idle_full", bus.full, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
